// File: rtl/output_arbiter_pkg.sv
// Shared NoC definitions: default sizing, burst lengths, arbiter state encoding
// and the port index helpers used by the port controllers and output arbiters.
package output_arbiter_pkg;

    localparam int default_flit_size    = 4;
    localparam int default_packet_size  = 32;
    localparam int default_address_size = 16;
    localparam int default_port_number  = 5;

    localparam int flit_number         = default_packet_size / default_flit_size;
    localparam int address_flit_number = default_address_size / default_flit_size;
    localparam int port_idx_w          = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Cyclic successor of a port index, wrapping at the last real port.
    function automatic logic [port_idx_w-1:0] next_port(input logic [port_idx_w-1:0] idx,
                                                        input int ports);
        return (int'(idx) == ports - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/output_arbiter_rr_pick.sv
// Round-robin search: first asserted request at or after rr_ptr, wrapping
// modulo port_number.
module rr_pick
    import output_arbiter_pkg::*;
#(
    parameter int port_number = default_port_number
) (
    input  logic [port_number-1:0] request,
    input  logic [port_idx_w-1:0]  rr_ptr,
    output logic                   found,
    output logic [port_idx_w-1:0]  winner
);

    int                  idx;
    logic [port_idx_w-1:0] idx_w;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int k = 0; k < port_number; k++) begin
            idx   = (int'(rr_ptr) + k) % port_number;
            idx_w = idx[port_idx_w-1:0];
            if (!found && request[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Output arbiter: grants one input port a fixed-length flit burst at a time,
// round-robin between competing ports, and stalls every other requester.
module output_arbiter
    import output_arbiter_pkg::*;
#(
    parameter int flit_size    = default_flit_size,
    parameter int packet_size  = default_packet_size,
    parameter int address_size = default_address_size,
    parameter int port_number  = default_port_number
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [port_number-1:0]                 request,
    input  logic [port_number*flit_size-1:0]       flit_in,
    output logic [port_number-1:0]                 stall,
    output logic [port_number-1:0]                 grant,
    output logic [port_idx_w-1:0]                  sel,
    output logic [flit_size-1:0]                   flit_out,
    output logic                                   flit_valid,
    output arb_state_t                             state,
    output logic [$clog2(packet_size/flit_size)-1:0] counter,
    output logic [port_idx_w-1:0]                  rr_ptr
);

    localparam int burst_len = packet_size / flit_size;
    localparam int cnt_w     = $clog2(burst_len);
    localparam logic [cnt_w-1:0] last_count = cnt_w'(burst_len - 1);

    arb_state_t            state_next;
    logic [port_idx_w-1:0] owner;
    logic                  found;
    logic [port_idx_w-1:0] winner;
    logic                  last_beat;
    logic                  arb_cycle;
    logic                  take;

    rr_pick #(.port_number(port_number)) u_pick (
        .request (request),
        .rr_ptr  (rr_ptr),
        .found   (found),
        .winner  (winner)
    );

    // The last beat of a burst doubles as an arbitration slot so bursts chain gap-free.
    assign last_beat = (state == BUSY) && (counter == last_count);
    assign arb_cycle = (state == IDLE) || last_beat;
    assign take      = arb_cycle && found;
    assign sel       = owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (take)           state_next = BUSY;
        else if (last_beat) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= '0;
            counter    <= '0;
            rr_ptr     <= '0;
            grant      <= '0;
            flit_valid <= 1'b0;
        end else if (take) begin
            owner      <= winner;
            counter    <= '0;
            rr_ptr     <= next_port(winner, port_number);
            grant      <= {{(port_number-1){1'b0}}, 1'b1} << winner;
            flit_valid <= 1'b1;
        end else if (last_beat) begin
            counter    <= '0;
            grant      <= '0;
            flit_valid <= 1'b0;
        end else if (state == BUSY) begin
            counter    <= counter + 1'b1;
        end
    end

    always_comb begin
        stall = request;
        if (take) stall[winner] = 1'b0;
        flit_out = '0;
        if (state == BUSY) flit_out = flit_in[owner*flit_size +: flit_size];
    end

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 Parameter flit_size, default 4, bits per flit.
REQ-002 Parameter packet_size, default 32, bits per packet; flit_number = packet_size/flit_size (8).
REQ-003 Parameter address_size, default 16, address bits; address_flit_number = address_size/flit_size (4).
REQ-004 Parameter port_number, default 5, number of input port controllers competing for this output.
REQ-005 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 request  input  port_number  bit i is port i's current_address_ready, already decoded for this output.
REQ-008 flit_in  input  port_number*flit_size  flit i occupies bits [i*flit_size +: flit_size].
REQ-009 stall  output  port_number  combinational; bit i goes to port i's stall input.
REQ-010 grant  output  port_number  registered, one-hot owner during BUSY, else 0.
REQ-011 sel  output  3  registered owner index.
REQ-012 flit_out  output  flit_size  combinational; flit_in[sel] in BUSY, else 0.
REQ-013 flit_valid  output  1  registered, high exactly while BUSY.

Function
REQ-014 Two states SHALL exist: IDLE and BUSY.
REQ-015 State SHALL be held in owner (3 b), counter (ceil(log2(flit_number)) b) and rr_ptr (3 b).
REQ-016 An arbitration cycle SHALL be any IDLE cycle, plus the BUSY cycle where counter == flit_number-1.
REQ-017 In an arbitration cycle with any request bit set, the winner SHALL be the first set bit at or after rr_ptr, searched cyclically modulo port_number.
REQ-018 In an arbitration cycle, stall[winner] SHALL be 0.
REQ-019 stall[i] SHALL be 1 for every other i with request[i]=1.
REQ-020 stall[i] SHALL be 0 for every i with request[i]=0.
REQ-021 In a non-arbitration BUSY cycle, stall SHALL equal request; a request from the current owner is also stalled.
REQ-022 On a grant, the next edge SHALL set state=BUSY, owner=winner, counter=0 and rr_ptr = (winner+1) mod port_number.
REQ-023 In BUSY, counter SHALL increment by 1 per cycle.
REQ-024 At counter == flit_number-1 with no winner, BUSY SHALL return to IDLE.
REQ-025 At counter == flit_number-1 with a winner, BUSY SHALL restart at counter=0 with the new owner, leaving no idle gap.
REQ-026 Latency: a request granted at cycle T SHALL give flit_valid=1, sel=winner for cycles T+1..T+flit_number.
REQ-027 This window SHALL match the port controller's address+payload burst.
REQ-028 Request bits with index >= port_number SHALL be ignored.
REQ-029 rr_ptr SHALL never exceed port_number-1.
REQ-030 rr_ptr SHALL be unchanged when no grant occurs.
REQ-031 A request that drops while stalled SHALL be dropped silently; no request state is latched.

Reset
REQ-032 Reset SHALL force state=IDLE, owner=0, counter=0, rr_ptr=0, grant=0, sel=0 and flit_valid=0 immediately, independent of clk.
REQ-033 Reset asserted mid-BUSY SHALL abort the burst; the first cycle after release is an IDLE arbitration cycle.

Structure
REQ-034 flit_number, address_flit_number, the state encodings and the port index width SHALL live in the shared NoC package used by port_controller.
REQ-035 The cyclic priority search SHALL be one sub-module, rr_pick (inputs: request, rr_ptr; outputs: found, winner).
REQ-036 All remaining logic SHALL stay in output_arbiter.

Verification
REQ-037 Single request: request=5'b00100 from IDLE at T -> stall=0 at T; T+1..T+8 flit_valid=1, sel=2, grant=5'b00100, flit_out=flit_in[2]; IDLE at T+9, rr_ptr=3.
REQ-038 Contention: request=5'b10011 with rr_ptr=0 -> port 0 wins, stall=5'b10010; after its burst (rr_ptr=1) port 1 wins; then rr_ptr=2 and port 4 wins.
REQ-039 Back-to-back: port 3 busy and port 1 requesting at counter=7 -> stall[1]=0 that cycle; next cycle sel=1, counter=0, flit_valid stays 1 with no gap.
REQ-040 Wrap: rr_ptr=4, request=5'b00011 -> port 0 wins; rr_ptr=1 afterwards.
REQ-041 Reset mid-burst: assert reset at counter=3 -> flit_valid, grant, sel = 0 asynchronously; after release, pending request=5'b01000 is granted in the first cycle.
REQ-042 Stall hold: port 2 requesting throughout port 0's 8-cycle burst -> stall[2]=1 for 7 cycles, 0 at counter=7, then port 2 owns 8 cycles.
